// File: rtl/cook_sequencer_if.sv
// Keypad/button/timer bundle for the microwave cook sequencer.
// Handshake: key_valid is a one-cycle pulse qualifying key_code; there is no
// ready, the sequencer samples every pulse and silently drops codes above 9
// or keys that arrive while cooking, paused or beeping. All other inputs are
// levels sampled on every clock edge; all outputs are registered levels except
// count_en, which is a one-cycle pulse per 1-second tick.
interface cook_sequencer_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        startn;
  logic        stopn;
  logic        door_closed;
  logic        timer_zero;
  logic        load_n;
  logic        count_en;
  logic        timer_clearn;
  logic [15:0] entry;
  logic        mag_on;
  logic        beep;
  logic [2:0]  state;

  // Environment side: drives buttons/keypad/timer status, observes controls.
  modport master (
    output key_valid, key_code, startn, stopn, door_closed, timer_zero,
    input  load_n, count_en, timer_clearn, entry, mag_on, beep, state
  );

  // Sequencer side.
  modport slave (
    input  key_valid, key_code, startn, stopn, door_closed, timer_zero,
    output load_n, count_en, timer_clearn, entry, mag_on, beep, state
  );
endinterface

// File: rtl/cook_sequencer.sv
// Microwave control FSM: gathers a 4-digit BCD MM:SS entry from the keypad,
// loads it into the external down-counter, paces it with a 1-second tick,
// drives the magnetron and sequences door/stop/beep handling.
module cook_sequencer #(
  parameter int TICK_DIV   = 100,
  parameter int BEEP_TICKS = 3
) (
  input logic             clock,
  input logic             clearn,
  cook_sequencer_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = $clog2(BEEP_TICKS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BEEP_LAST  = BW'(BEEP_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_COOK  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     entry_q, entry_d;
  logic            load_n_q, load_n_d;
  logic            count_en_q, count_en_d;
  logic            timer_clearn_q, timer_clearn_d;
  logic            mag_on_q, mag_on_d;
  logic            beep_q, beep_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [BW-1:0]   beep_cnt_q, beep_cnt_d;
  logic            startn_q, stopn_q;

  logic start_ev, stop_ev, tick, key_ok;

  // Falling edges of the debounced buttons, plus tick and accepted-key decode.
  always_comb begin
    start_ev = startn_q & ~bus.startn;
    stop_ev  = stopn_q & ~bus.stopn;
    tick     = (presc_q == PRESC_LAST);
    key_ok   = bus.key_valid && (bus.key_code <= 4'd9);
  end

  // Next-state and registered-output logic; the load pulse itself marks the
  // one-cycle gap between accepting start and entering COOK.
  always_comb begin
    state_d        = state_q;
    entry_d        = entry_q;
    load_n_d       = 1'b1;
    count_en_d     = 1'b0;
    timer_clearn_d = 1'b1;
    beep_d         = 1'b0;
    presc_d        = presc_q;
    beep_cnt_d     = beep_cnt_q;
    case (state_q)
      S_IDLE, S_ENTRY: begin
        if (stop_ev) begin
          state_d        = S_IDLE;
          entry_d        = '0;
          timer_clearn_d = 1'b0;
        end else if (!load_n_q) begin
          state_d = S_COOK;
          presc_d = '0;
        end else if (state_q == S_ENTRY && start_ev) begin
          if (bus.door_closed && entry_q != 16'h0000) load_n_d = 1'b0;
        end else if (key_ok) begin
          entry_d = {entry_q[11:0], bus.key_code};
          state_d = S_ENTRY;
        end
      end
      S_COOK: begin
        if (stop_ev) begin
          state_d = S_PAUSE;
        end else if (bus.timer_zero) begin
          state_d    = S_DONE;
          presc_d    = '0;
          beep_cnt_d = '0;
          beep_d     = 1'b1;
        end else if (!bus.door_closed) begin
          state_d = S_PAUSE;
        end else begin
          count_en_d = tick;
          presc_d    = tick ? '0 : presc_q + PW'(1);
        end
      end
      S_PAUSE: begin
        if (stop_ev) begin
          state_d        = S_IDLE;
          entry_d        = '0;
          timer_clearn_d = 1'b0;
        end else if (bus.door_closed && start_ev) begin
          state_d = S_COOK;
        end
      end
      S_DONE: begin
        if (stop_ev) begin
          state_d = S_IDLE;
          entry_d = '0;
        end else if (tick) begin
          presc_d = '0;
          if (beep_cnt_q == BEEP_LAST) begin
            state_d    = S_IDLE;
            entry_d    = '0;
            beep_cnt_d = '0;
          end else begin
            beep_d     = 1'b1;
            beep_cnt_d = beep_cnt_q + BW'(1);
          end
        end else begin
          beep_d  = 1'b1;
          presc_d = presc_q + PW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        entry_d = '0;
      end
    endcase
    mag_on_d = (state_d == S_COOK);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!clearn) begin
      state_q        <= S_IDLE;
      entry_q        <= '0;
      load_n_q       <= 1'b1;
      count_en_q     <= 1'b0;
      timer_clearn_q <= 1'b0;
      mag_on_q       <= 1'b0;
      beep_q         <= 1'b0;
      presc_q        <= '0;
      beep_cnt_q     <= '0;
      startn_q       <= 1'b1;
      stopn_q        <= 1'b1;
    end else begin
      state_q        <= state_d;
      entry_q        <= entry_d;
      load_n_q       <= load_n_d;
      count_en_q     <= count_en_d;
      timer_clearn_q <= timer_clearn_d;
      mag_on_q       <= mag_on_d;
      beep_q         <= beep_d;
      presc_q        <= presc_d;
      beep_cnt_q     <= beep_cnt_d;
      startn_q       <= bus.startn;
      stopn_q        <= bus.stopn;
    end
  end

  assign bus.state        = state_q;
  assign bus.entry        = entry_q;
  assign bus.load_n       = load_n_q;
  assign bus.count_en     = count_en_q;
  assign bus.timer_clearn = timer_clearn_q;
  assign bus.mag_on       = mag_on_q;
  assign bus.beep         = beep_q;
endmodule

// File: tb/tb_cook_sequencer.sv
// Directed bench for cook_sequencer (TICK_DIV=4, BEEP_TICKS=2).
module tb_cook_sequencer;
  localparam int W = 24;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_ENTRY = 3'd1, ST_COOK = 3'd2,
                         ST_PAUSE = 3'd3, ST_DONE = 3'd4;

  logic clock;
  logic clearn;
  int   cyc;
  int   chk_cnt;
  int   pass_cnt;

  logic [W-1:0] exp_q[$];
  int           cyc_q[$];
  string        name_q[$];

  cook_sequencer_if bus();

  cook_sequencer #(.TICK_DIV(4), .BEEP_TICKS(2)) dut (
    .clock (clock),
    .clearn(clearn),
    .bus   (bus)
  );

  // Clock, cycle counter and watchdog.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, %0d expectations still queued", exp_q.size());
    $fatal(1, "timeout");
  end

  // Driver helpers.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic logic [W-1:0] ov(input logic [2:0] st, input logic ld, input logic ce,
                                      input logic clr, input logic mag, input logic bp,
                                      input logic [15:0] ent);
    return {st, ld, ce, clr, mag, bp, ent};
  endfunction

  task automatic expect_at(input int dc, input string nm, input logic [W-1:0] v);
    exp_q.push_back(v);
    cyc_q.push_back(cyc + dc);
    name_q.push_back(nm);
  endtask

  task automatic press_key(input logic [3:0] code, input logic [2:0] st, input logic [15:0] ent);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    expect_at(1, $sformatf("key_%0h", code), ov(st, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ent));
    step(1);
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
  endtask

  // Monitor: compares queued expectations at the cycle they target.
  always @(negedge clock) begin
    logic [W-1:0] act;
    act = {bus.state, bus.load_n, bus.count_en, bus.timer_clearn, bus.mag_on, bus.beep, bus.entry};
    while (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
      logic [W-1:0] e;
      int           c;
      string        nm;
      e  = exp_q.pop_front();
      c  = cyc_q.pop_front();
      nm = name_q.pop_front();
      chk_cnt++;
      if (c != cyc)
        $display("FAIL %s: expectation for cycle %0d seen late at cycle %0d", nm, c, cyc);
      else if (act !== e)
        $display("FAIL %s @%0d: got st=%0d ld=%b ce=%b clr=%b mag=%b bp=%b entry=%h, want st=%0d ld=%b ce=%b clr=%b mag=%b bp=%b entry=%h",
                 nm, cyc, act[23:21], act[20], act[19], act[18], act[17], act[16], act[15:0],
                 e[23:21], e[20], e[19], e[18], e[17], e[16], e[15:0]);
      else
        pass_cnt++;
    end
  end

  // Stimulus.
  initial begin
    chk_cnt         = 0;
    pass_cnt        = 0;
    clearn          = 1'b0;
    bus.key_valid   = 1'b0;
    bus.key_code    = 4'h0;
    bus.startn      = 1'b1;
    bus.stopn       = 1'b1;
    bus.door_closed = 1'b1;
    bus.timer_zero  = 1'b0;
    step(2);
    expect_at(0, "reset_vals", ov(ST_IDLE, 1, 0, 0, 0, 0, 16'h0000));
    clearn = 1'b1;
    expect_at(1, "clearn_release", ov(ST_IDLE, 1, 0, 1, 0, 0, 16'h0000));
    step(1);

    // Digit entry, shifting, invalid code.
    press_key(4'h1, ST_ENTRY, 16'h0001);
    press_key(4'h2, ST_ENTRY, 16'h0012);
    press_key(4'h3, ST_ENTRY, 16'h0123);
    press_key(4'h0, ST_ENTRY, 16'h1230);
    press_key(4'h5, ST_ENTRY, 16'h2305);
    press_key(4'hB, ST_ENTRY, 16'h2305);

    // Stop in ENTRY clears everything.
    bus.stopn = 1'b0;
    expect_at(1, "stop_entry", ov(ST_IDLE, 1, 0, 0, 0, 0, 16'h0000));
    step(1);
    bus.stopn = 1'b1;
    expect_at(1, "stop_clr_release", ov(ST_IDLE, 1, 0, 1, 0, 0, 16'h0000));
    step(1);

    // Entry 0003, start, tick pacing.
    press_key(4'h0, ST_ENTRY, 16'h0000);
    press_key(4'h0, ST_ENTRY, 16'h0000);
    press_key(4'h0, ST_ENTRY, 16'h0000);
    press_key(4'h3, ST_ENTRY, 16'h0003);
    bus.startn = 1'b0;
    expect_at(1, "load_pulse", ov(ST_ENTRY, 0, 0, 1, 0, 0, 16'h0003));
    for (int k = 2; k <= 10; k++)
      expect_at(k, $sformatf("cook_%0d", k),
                ov(ST_COOK, 1, (k == 6 || k == 10), 1, 1, 0, 16'h0003));
    step(1);
    bus.startn = 1'b1;
    step(11);

    // Door opens: pause with frozen prescaler (phase 2).
    bus.door_closed = 1'b0;
    for (int k = 1; k <= 4; k++)
      expect_at(k, $sformatf("pause_%0d", k), ov(ST_PAUSE, 1, 0, 1, 0, 0, 16'h0003));
    step(4);
    bus.door_closed = 1'b1;
    bus.startn      = 1'b0;
    for (int k = 1; k <= 4; k++)
      expect_at(k, $sformatf("resume_%0d", k), ov(ST_COOK, 1, (k == 3), 1, 1, 0, 16'h0003));
    step(1);
    bus.startn = 1'b1;
    step(3);

    // Timer reaches zero: DONE with 8 beep cycles, then IDLE.
    bus.timer_zero = 1'b1;
    for (int k = 1; k <= 8; k++)
      expect_at(k, $sformatf("done_%0d", k), ov(ST_DONE, 1, 0, 1, 0, 1, 16'h0003));
    expect_at(9, "done_exit", ov(ST_IDLE, 1, 0, 1, 0, 0, 16'h0000));
    step(1);
    bus.timer_zero = 1'b0;
    step(9);

    // Start rejected while the door is open.
    press_key(4'h1, ST_ENTRY, 16'h0001);
    bus.door_closed = 1'b0;
    bus.startn      = 1'b0;
    expect_at(1, "start_door_open_1", ov(ST_ENTRY, 1, 0, 1, 0, 0, 16'h0001));
    expect_at(2, "start_door_open_2", ov(ST_ENTRY, 1, 0, 1, 0, 0, 16'h0001));
    step(1);
    bus.startn      = 1'b1;
    bus.door_closed = 1'b1;
    step(1);

    // Start, stop to PAUSE, then stop+start together in PAUSE.
    bus.startn = 1'b0;
    expect_at(1, "load_b", ov(ST_ENTRY, 0, 0, 1, 0, 0, 16'h0001));
    expect_at(2, "cook_b", ov(ST_COOK, 1, 0, 1, 1, 0, 16'h0001));
    step(1);
    bus.startn = 1'b1;
    step(1);
    bus.stopn = 1'b0;
    expect_at(1, "stop_cook", ov(ST_PAUSE, 1, 0, 1, 0, 0, 16'h0001));
    step(1);
    bus.stopn = 1'b1;
    step(1);
    bus.stopn  = 1'b0;
    bus.startn = 1'b0;
    expect_at(1, "stop_start_pause", ov(ST_IDLE, 1, 0, 0, 0, 0, 16'h0000));
    expect_at(2, "stop_start_after", ov(ST_IDLE, 1, 0, 1, 0, 0, 16'h0000));
    step(1);
    bus.stopn  = 1'b1;
    bus.startn = 1'b1;
    step(1);

    // Reset mid-COOK with start held low through reset.
    press_key(4'h7, ST_ENTRY, 16'h0007);
    bus.startn = 1'b0;
    expect_at(1, "load_c", ov(ST_ENTRY, 0, 0, 1, 0, 0, 16'h0007));
    expect_at(2, "cook_c", ov(ST_COOK, 1, 0, 1, 1, 0, 16'h0007));
    step(1);
    bus.startn = 1'b1;
    step(2);
    clearn     = 1'b0;
    bus.startn = 1'b0;
    expect_at(1, "reset_mid_cook", ov(ST_IDLE, 1, 0, 0, 0, 0, 16'h0000));
    step(1);
    clearn = 1'b1;
    expect_at(1, "reset_release_c", ov(ST_IDLE, 1, 0, 1, 0, 0, 16'h0000));
    step(2);
    press_key(4'h5, ST_ENTRY, 16'h0005);
    for (int k = 1; k <= 3; k++)
      expect_at(k, $sformatf("held_start_%0d", k), ov(ST_ENTRY, 1, 0, 1, 0, 0, 16'h0005));
    step(3);
    bus.startn = 1'b1;
    step(2);

    // Drain: every queued expectation must have been consumed.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1);
    chk_cnt++;
    if (exp_q.size() != 0)
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    else
      pass_cnt++;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
